// File: rtl/loop_acc.sv
// loop_acc: sums one loop's sign-extended beats and presents sum/count on a valid/ready port.
// Optional saturating arithmetic with a sticky overflow flag when LOOP_ACC_SAT_EN is defined.
module loop_acc #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          next,
    input  logic          last,
    input  logic [DW-1:0] data,
    output logic          en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic [CW-1:0] out_cnt,
    output logic          out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_acc_nx;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nx;
    logic                r_sticky;
    logic                w_sticky_nx;
    logic                r_out_valid;
    logic                w_out_valid_nx;
    logic [AW-1:0]       r_out_data;
    logic [AW-1:0]       w_out_data_nx;
    logic [CW-1:0]       r_out_cnt;
    logic [CW-1:0]       w_out_cnt_nx;
    logic                r_out_ovf;
    logic                w_out_ovf_nx;

    logic signed [AW-1:0] w_sext;
    logic signed [AW-1:0] w_sum;
    logic                w_sat;
    logic                w_accept;

    assign w_sext = AW'($signed(data));

`ifdef LOOP_ACC_SAT_EN
    localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

    logic signed [AW:0] w_sum_wide;

    // One extra bit exposes signed overflow: top two bits disagree.
    assign w_sum_wide = (AW+1)'(r_acc) + (AW+1)'(w_sext);
    assign w_sat      = w_sum_wide[AW] ^ w_sum_wide[AW-1];
    assign w_sum      = w_sat ? (w_sum_wide[AW] ? SAT_MIN : SAT_MAX) : w_sum_wide[AW-1:0];
`else
    assign w_sum = r_acc + w_sext;
    assign w_sat = 1'b0;
`endif

    // Only the result register can stall the counter; en never looks at next.
    assign en       = (r_state != S_HOLD) || out_ready;
    assign w_accept = next && en;

    always_comb begin
        w_state_nx     = r_state;
        w_acc_nx       = r_acc;
        w_cnt_nx       = r_cnt;
        w_sticky_nx    = r_sticky;
        w_out_valid_nx = r_out_valid;
        w_out_data_nx  = r_out_data;
        w_out_cnt_nx   = r_out_cnt;
        w_out_ovf_nx   = r_out_ovf;

        case (r_state)
            S_IDLE, S_HOLD: begin
                if (r_state == S_HOLD && out_ready) begin
                    w_out_valid_nx = 1'b0;
                    w_state_nx     = S_IDLE;
                end
                // HOLD with out_ready behaves as IDLE in the same cycle, so no bubble.
                if (w_accept) begin
                    if (last) begin
                        w_out_data_nx  = w_sext;
                        w_out_cnt_nx   = CW'(1);
                        w_out_ovf_nx   = 1'b0;
                        w_out_valid_nx = 1'b1;
                        w_state_nx     = S_HOLD;
                    end else begin
                        w_acc_nx    = w_sext;
                        w_cnt_nx    = CW'(1);
                        w_sticky_nx = 1'b0;
                        w_state_nx  = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (w_accept) begin
                    if (last) begin
                        w_out_data_nx  = w_sum;
                        w_out_cnt_nx   = r_cnt + CW'(1);
                        w_out_ovf_nx   = r_sticky | w_sat;
                        w_out_valid_nx = 1'b1;
                        w_acc_nx       = '0;
                        w_cnt_nx       = '0;
                        w_sticky_nx    = 1'b0;
                        w_state_nx     = S_HOLD;
                    end else begin
                        w_acc_nx    = w_sum;
                        w_cnt_nx    = r_cnt + CW'(1);
                        w_sticky_nx = r_sticky | w_sat;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_acc       <= w_acc_nx;
            r_cnt       <= w_cnt_nx;
            r_sticky    <= w_sticky_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_data  <= w_out_data_nx;
            r_out_cnt   <= w_out_cnt_nx;
            r_out_ovf   <= w_out_ovf_nx;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;

endmodule

// File: doc/loop_acc.md
Name: loop_acc

Overview:
- Consumer end of the loop-iteration interface: receives the per-iteration beat stream (next strobe, last strobe, data) from a loop counter and returns the enable that throttles that counter.
- Sign-extends and sums every accepted beat. On the last beat it presents the sum and the beat count on a valid/ready result port.
- Sits behind a loop counter in the MNIST datapath to reduce an inner loop (e.g. partial products of one output neuron) to one value.

Parameters:
- DW, 16, width of incoming beat data (signed two's complement)
- AW, 32, accumulator and result width (signed); AW >= DW
- CW, 16, beat-count width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- next  input  1  beat strobe from loop counter; beat present this cycle
- last  input  1  final beat of the loop; only meaningful with next=1
- data  input  DW  signed beat data
- en  output  1  enable back to loop counter; beat accepted when next & en
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result when out_valid & out_ready
- out_data  output  AW  accumulated sum
- out_cnt  output  CW  number of beats in the loop
- out_ovf  output  1  saturation occurred in this result (0 when feature off)

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_cnt=0, out_ovf=0, sticky ovf=0. rst has priority over all other inputs and aborts any partial loop mid-operation.
- States:
  - IDLE: no loop in progress.
  - ACC: loop in progress, at least one beat taken.
  - HOLD: result presented.
- en is combinational: 1 in IDLE and ACC; in HOLD, en = out_ready. It never depends on next.
- Accept = next & en. Sext = data sign-extended to AW.
- IDLE + accept:
  - last=0: acc=Sext, cnt=1, go to ACC.
  - last=1: out_data=Sext, out_cnt=1, out_valid=1, go to HOLD. This is a single-beat loop.
- ACC + accept:
  - last=0: acc=acc+Sext, cnt=cnt+1.
  - last=1: out_data=acc+Sext, out_cnt=cnt+1, out_valid=1, go to HOLD. acc and cnt cleared.
- ACC without accept: hold all state. Gaps between beats are legal at any length.
- HOLD:
  - out_data, out_cnt and out_ovf are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid=0 next cycle, state=IDLE, unless a beat is accepted in the same cycle.
  - Simultaneous retire + accept (en=out_ready=1): the result retires and the beat is processed exactly as in IDLE. No bubble cycle.
- Latency: result valid the cycle after the last beat is accepted.
- last with next=0: ignored.
- Arithmetic without the optional feature: modulo 2^AW wrap-around, no flag.
- cnt wraps modulo 2^CW; out_cnt=0 denotes 2^CW beats.
- out_data/out_cnt keep their last values after retire. Only out_valid drops.

Optional Feature:
- LOOP_ACC_SAT_EN
- Defined:
  - Each addition saturates to the signed AW range, +(2^(AW-1)-1) or -2^(AW-1).
  - Any saturation sets a sticky flag for the current loop.
  - out_ovf is the sticky value at result time; the flag clears when the result is produced and on rst.
- Undefined:
  - Wrap-around arithmetic.
  - out_ovf tied to 0; port still present.

Test Plan:
- Loop of 4 beats, data 1,2,3,-4, last on 4th, out_ready=1 -> out_valid one cycle after beat 4; out_data=2, out_cnt=4, out_ovf=0.
- Single beat: next=last=1, data=-5 (DW=16) -> out_data=0xFFFFFFFB, out_cnt=1, next state HOLD.
- Backpressure: result pending, out_ready=0 for 5 cycles while next=1 -> en=0 throughout, no beat consumed, outputs stable. Then out_ready=1 with next=1, data=7 -> retire and new loop start in the same cycle; acc=7.
- rst asserted after 2 of 3 beats (10,20) -> out_valid=0, state IDLE. A following 1-beat loop with data=3 yields out_data=3, out_cnt=1.
- AW=DW=16, beats 0x7FFF,0x0001 -> without LOOP_ACC_SAT_EN: out_data=0x8000, out_ovf=0. With LOOP_ACC_SAT_EN: out_data=0x7FFF, out_ovf=1. Next loop (data 1, last) gives out_ovf=0.
- Gapped input: beats with next low 3 cycles between each, data 5,5,5 -> out_data=15, out_cnt=3; en stays 1 through all gaps.
